// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the two-master data bus arbiter: FSM encodings,
// master ids, the latched-transaction record and the address map helpers.
package data_bus_arbiter_pkg;

  // Arbiter FSM encoding; values are fixed so debug tools can decode them.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // Master identifiers as carried on bus_owner.
  localparam logic MASTER_M0 = 1'b0;
  localparam logic MASTER_M1 = 1'b1;

  // Address map of the peripheral fabric (base/mask pairs).
  localparam logic [31:0] INSTR_BASE = 32'h0000_0000;
  localparam logic [31:0] INSTR_MASK = 32'hFFFF_0000;
  localparam logic [31:0] DATA_BASE  = 32'h1000_0000;
  localparam logic [31:0] DATA_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] TIMER_BASE = 32'h2000_0000;
  localparam logic [31:0] TIMER_MASK = 32'hFFFF_FF00;
  localparam logic [31:0] UART_BASE  = 32'h3000_0000;
  localparam logic [31:0] UART_MASK  = 32'hFFFF_FF00;

  // Everything about a granted transaction that is frozen at grant time.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic [2:0]  load_type;
    logic        owner;
    logic        mapped;
  } txn_t;

  function automatic logic is_instr_mem(input logic [31:0] addr);
    return (addr & INSTR_MASK) == INSTR_BASE;
  endfunction

  function automatic logic is_data_mem(input logic [31:0] addr);
    return (addr & DATA_MASK) == DATA_BASE;
  endfunction

  function automatic logic is_timer_mem(input logic [31:0] addr);
    return (addr & TIMER_MASK) == TIMER_BASE;
  endfunction

  function automatic logic is_uart_mem(input logic [31:0] addr);
    return (addr & UART_MASK) == UART_BASE;
  endfunction

  // An address is mapped when any slave region claims it.
  function automatic logic is_mapped(input logic [31:0] addr);
    return is_instr_mem(addr) | is_data_mem(addr) |
           is_timer_mem(addr) | is_uart_mem(addr);
  endfunction

endpackage

// File: rtl/data_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick. The pointer (last_owner) is held
// by the parent; this block only decides who wins this cycle.
module rr_pick2
  import data_bus_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_id
);

  // A lone requester always wins; on contention the master not served last wins.
  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = MASTER_M0;
    if (req0 && req1) begin
      grant_id = ~last_owner;
    end else if (req1) begin
      grant_id = MASTER_M1;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter. One transaction at a time walks
// IDLE -> ACCESS -> RESP; the slave strobe is only ever raised in ACCESS.
//
// Handshake: a master raises mX_req with all fields stable and keeps them
// until it sees mX_ack (a single-cycle pulse, with mX_err/mX_rdata valid in
// the same cycle). Fields are sampled once, on the grant edge. A request
// still high in the IDLE cycle after ack is taken as a new transaction.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter bit M0_FIRST        = 1'b1,
  parameter bit ERR_ON_UNMAPPED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byte_en,
  input  logic [2:0]  m0_load_type,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byte_en,
  input  logic [2:0]  m1_load_type,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        bus_wr_en,
  output logic        bus_rd_en,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byte_en,
  output logic [2:0]  bus_load_type,
  input  logic [31:0] bus_rdata,
  output logic        bus_owner
);

  // Pointer reset value is "the other master", so the preferred one wins first.
  localparam logic PTR_RESET = M0_FIRST ? MASTER_M1 : MASTER_M0;
  localparam logic ERR_EN    = ERR_ON_UNMAPPED;

  arb_state_e  state_q, state_d;
  logic        last_owner_q, last_owner_d;
  txn_t        txn_q, txn_d;
  logic        err_q, err_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic        grant_valid;
  logic        grant_id;
  logic        do_grant;
  logic        txn_err;
  logic        strobe_ok;

  rr_pick2 u_pick (
    .req0        (m0_req),
    .req1        (m1_req),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign do_grant  = (state_q == ST_IDLE) && grant_valid;
  // Unmapped accesses are suppressed only when error reporting is enabled.
  assign txn_err   = ERR_EN & ~txn_q.mapped;
  assign strobe_ok = ~txn_err;

  // State register plus all datapath flops; reset aborts any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= PTR_RESET;
      txn_q        <= '0;
      err_q        <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      txn_q        <= txn_d;
      err_q        <= err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // Next-state: ACCESS and RESP each last exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Grant-time latch of the winner's fields and pointer update.
  always_comb begin
    txn_d        = txn_q;
    last_owner_d = last_owner_q;
    if (do_grant) begin
      last_owner_d = grant_id;
      txn_d.owner  = grant_id;
      if (grant_id == MASTER_M1) begin
        txn_d.we        = m1_we;
        txn_d.addr      = m1_addr;
        txn_d.wdata     = m1_wdata;
        txn_d.byte_en   = m1_byte_en;
        txn_d.load_type = m1_load_type;
        txn_d.mapped    = is_mapped(m1_addr);
      end else begin
        txn_d.we        = m0_we;
        txn_d.addr      = m0_addr;
        txn_d.wdata     = m0_wdata;
        txn_d.byte_en   = m0_byte_en;
        txn_d.load_type = m0_load_type;
        txn_d.mapped    = is_mapped(m0_addr);
      end
    end
  end

  // Response capture at the end of ACCESS: read data lands in the owner's
  // rdata register, writes leave it untouched, errors force it to zero.
  always_comb begin
    err_d      = err_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    if (state_q == ST_ACCESS) begin
      err_d = txn_err;
      if (txn_err) begin
        if (txn_q.owner == MASTER_M1) m1_rdata_d = '0;
        else                          m0_rdata_d = '0;
      end else if (!txn_q.we) begin
        if (txn_q.owner == MASTER_M1) m1_rdata_d = bus_rdata;
        else                          m0_rdata_d = bus_rdata;
      end
    end
  end

  // Outputs decoded from state: strobes in ACCESS, ack/err to the owner in RESP.
  always_comb begin
    bus_wr_en     = 1'b0;
    bus_rd_en     = 1'b0;
    m0_ack        = 1'b0;
    m1_ack        = 1'b0;
    m0_err        = 1'b0;
    m1_err        = 1'b0;
    bus_addr      = txn_q.addr;
    bus_wdata     = txn_q.wdata;
    bus_byte_en   = txn_q.byte_en;
    bus_load_type = txn_q.load_type;
    bus_owner     = txn_q.owner;
    m0_rdata      = m0_rdata_q;
    m1_rdata      = m1_rdata_q;
    case (state_q)
      ST_ACCESS: begin
        bus_wr_en = txn_q.we & strobe_ok;
        bus_rd_en = ~txn_q.we & strobe_ok;
      end
      ST_RESP: begin
        if (txn_q.owner == MASTER_M1) begin
          m1_ack = 1'b1;
          m1_err = err_q;
        end else begin
          m0_ack = 1'b1;
          m0_err = err_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter with a small word-addressed slave
// model standing in for the decode/read-mux fabric.
module tb_data_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_byte_en;
  logic [2:0]  m0_load_type;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_byte_en;
  logic [2:0]  m1_load_type;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdata;
  logic        bus_wr_en, bus_rd_en;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_byte_en;
  logic [2:0]  bus_load_type;
  logic [31:0] bus_rdata;
  logic        bus_owner;

  int n_checks;
  int n_pass;
  logic [31:0] exp_q[$];

  data_bus_arbiter #(.M0_FIRST(1'b1), .ERR_ON_UNMAPPED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_byte_en(m0_byte_en), .m0_load_type(m0_load_type),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_byte_en(m1_byte_en), .m1_load_type(m1_load_type),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en),
    .bus_load_type(bus_load_type), .bus_rdata(bus_rdata), .bus_owner(bus_owner)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: 64 words indexed by addr[7:2], byte-enabled writes.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h55AA_55AA;
      mem[1] <= 32'hCAFE_0001;
      mem[4] <= 32'hDEAD_BEEF;
      mem[8] <= 32'h1122_3344;
    end else if (bus_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (bus_byte_en[b]) mem[bus_addr[7:2]][8*b +: 8] <= bus_wdata[8*b +: 8];
    end
  end
  assign bus_rdata = mem[bus_addr[7:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    m0_byte_en = be; m0_load_type = 3'd2;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    m1_byte_en = be; m1_load_type = 3'd4;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    step();
    // Reset state
    check("rst_wr_en",  32'(bus_wr_en), 32'd0);
    check("rst_rd_en",  32'(bus_rd_en), 32'd0);
    check("rst_acks",   {30'd0, m1_ack, m0_ack}, 32'd0);
    check("rst_errs",   {30'd0, m1_err, m0_err}, 32'd0);
    check("rst_rdata0", m0_rdata, 32'd0);
    check("rst_rdata1", m1_rdata, 32'd0);
    check("rst_addr",   bus_addr, 32'd0);
    check("rst_owner",  32'(bus_owner), 32'd0);
    check("rst_state",  32'(dut.state_q), 32'd0);
    rst = 1'b0;

    // M0 read alone
    drive_m0(1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'hF);
    check("t1_pre_rd", 32'(bus_rd_en), 32'd0);
    step();
    check("t1_rd_en",  32'(bus_rd_en), 32'd1);
    check("t1_wr_en",  32'(bus_wr_en), 32'd0);
    check("t1_addr",   bus_addr, 32'h1000_0010);
    check("t1_ltype",  32'(bus_load_type), 32'd2);
    check("t1_noack",  32'(m0_ack), 32'd0);
    step();
    check("t1_rd_off", 32'(bus_rd_en), 32'd0);
    check("t1_ack",    32'(m0_ack), 32'd1);
    check("t1_err",    32'(m0_err), 32'd0);
    check("t1_rdata",  m0_rdata, 32'hDEAD_BEEF);
    check("t1_m1ack",  32'(m1_ack), 32'd0);
    m0_req = 1'b0;
    step();
    check("t1_idle_ack", 32'(m0_ack), 32'd0);

    // M1 byte write, then M0 reads it back
    drive_m1(1'b1, 1'b1, 32'h1000_0020, 32'h0000_00A5, 4'b0001);
    step();
    check("t3_wr_en",  32'(bus_wr_en), 32'd1);
    check("t3_rd_en",  32'(bus_rd_en), 32'd0);
    check("t3_be",     32'(bus_byte_en), 32'h1);
    check("t3_wdata",  bus_wdata, 32'h0000_00A5);
    check("t3_owner",  32'(bus_owner), 32'd1);
    step();
    check("t3_wr_off", 32'(bus_wr_en), 32'd0);
    check("t3_ack",    32'(m1_ack), 32'd1);
    check("t3_err",    32'(m1_err), 32'd0);
    check("t3_rdhold", m1_rdata, 32'd0);
    m1_req = 1'b0;
    step();
    drive_m0(1'b1, 1'b0, 32'h1000_0020, 32'h0, 4'hF);
    step();
    check("t3_rb_rd",  32'(bus_rd_en), 32'd1);
    step();
    check("t3_rb_ack", 32'(m0_ack), 32'd1);
    check("t3_rb_data", m0_rdata, 32'h1122_33A5);
    m0_req = 1'b0;
    step();

    // M0 unmapped read
    drive_m0(1'b1, 1'b0, 32'hF000_0000, 32'h0, 4'hF);
    step();
    check("t4_no_rd",  32'(bus_rd_en), 32'd0);
    check("t4_no_wr",  32'(bus_wr_en), 32'd0);
    step();
    check("t4_ack",    32'(m0_ack), 32'd1);
    check("t4_err",    32'(m0_err), 32'd1);
    check("t4_rdata",  m0_rdata, 32'd0);
    m0_req = 1'b0;
    step();
    check("t4_err_off", 32'(m0_err), 32'd0);

    // Both request continuously from reset: strict alternation
    do_reset();
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hCAFE_0001);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hCAFE_0001);
    drive_m0(1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'hF);
    drive_m1(1'b1, 1'b0, 32'h2000_0004, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_data;
      logic        exp_id;
      exp_id   = k[0];
      exp_data = exp_q.pop_front();
      step();
      check("t2_owner", 32'(bus_owner), 32'(exp_id));
      check("t2_rd_en", 32'(bus_rd_en), 32'd1);
      check("t2_addr",  bus_addr, exp_id ? 32'h2000_0004 : 32'h1000_0010);
      step();
      check("t2_acks",  {30'd0, m1_ack, m0_ack}, exp_id ? 32'd2 : 32'd1);
      check("t2_rdata", exp_id ? m1_rdata : m0_rdata, exp_data);
      if (k == 3) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      step();
      check("t2_idle",  {30'd0, m1_ack, m0_ack, bus_rd_en}, 32'd0);
    end
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-ACCESS, held request completes afterwards
    drive_m0(1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'hF);
    step();
    check("t5_rd_en",  32'(bus_rd_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rd_drop", 32'(bus_rd_en), 32'd0);
    check("t5_wr_drop", 32'(bus_wr_en), 32'd0);
    check("t5_state",   32'(dut.state_q), 32'd0);
    check("t5_rdata",   m0_rdata, 32'd0);
    step();
    check("t5_noack",  32'(m0_ack), 32'd0);
    rst = 1'b0;
    step();
    check("t5_re_rd",  32'(bus_rd_en), 32'd1);
    check("t5_re_own", 32'(bus_owner), 32'd0);
    step();
    check("t5_re_ack", 32'(m0_ack), 32'd1);
    check("t5_re_data", m0_rdata, 32'hDEAD_BEEF);
    m0_req = 1'b0;
    step();

    // M1 arrives during M0 ACCESS
    drive_m0(1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'hF);
    step();
    check("t6_owner0", 32'(bus_owner), 32'd0);
    drive_m1(1'b1, 1'b0, 32'h2000_0004, 32'h0, 4'hF);
    step();
    check("t6_acks0",  {30'd0, m1_ack, m0_ack}, 32'd1);
    m0_req = 1'b0;
    step();
    check("t6_idle",   {30'd0, m1_ack, m0_ack, bus_rd_en}, 32'd0);
    step();
    check("t6_owner1", 32'(bus_owner), 32'd1);
    check("t6_rd_en",  32'(bus_rd_en), 32'd1);
    check("t6_ltype",  32'(bus_load_type), 32'd4);
    step();
    check("t6_acks1",  {30'd0, m1_ack, m0_ack}, 32'd2);
    check("t6_rdata1", m1_rdata, 32'hCAFE_0001);
    check("t6_rdata0", m0_rdata, 32'hDEAD_BEEF);
    m1_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      check("t6_no_dup", {30'd0, m1_ack, m0_ack}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Shares the single data/peripheral bus (data memory, timer, UART, instruction-memory read port) between two masters.
- M0 is the CPU load/store port. M1 is a secondary master (DMA or debug loader).
- Round-robin arbitration with registered request capture, one outstanding transaction at a time, and a decode-error response for unmapped addresses.
- Sits between riscv_cpu (plus the secondary master) and the existing address-decode/read-mux fabric.

Parameters:
- M0_FIRST, 1, after reset M0 wins the first simultaneous request (initial value of the round-robin pointer).
- ERR_ON_UNMAPPED, 1, when 1, accesses outside DATA/TIMER/UART/INSTR regions return err and generate no bus strobe.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- m0_req  in  1  M0 transaction request; held with fields stable until m0_ack
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  32  byte address
- m0_wdata  in  32  write data
- m0_byte_en  in  4  write byte enables
- m0_load_type  in  3  load type code
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  valid with m0_ack; unmapped address
- m0_rdata  out  32  read data, valid with m0_ack
- m1_req, m1_we, m1_addr, m1_wdata, m1_byte_en, m1_load_type, m1_ack, m1_err, m1_rdata  same as M0
- bus_wr_en  out  1  slave write strobe
- bus_rd_en  out  1  slave read strobe
- bus_addr  out  32  slave address
- bus_wdata  out  32  slave write data
- bus_byte_en  out  4  slave byte enables
- bus_load_type  out  3  slave load type
- bus_rdata  in  32  combinational read data from the decode mux
- bus_owner  out  1  id of the current/last granted master (debug)

Behaviour:
- Reset (async, immediate): state IDLE. All strobes, acks and errs 0. rdata outputs 0. bus_* address/data 0. bus_owner 0. Round-robin pointer set so that M0 wins first when M0_FIRST=1, M1 otherwise.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both req: grant the master not granted last (round-robin).
  - On grant: latch we/addr/wdata/byte_en/load_type/owner into registers, update pointer, go to ACCESS.
- ACCESS (exactly 1 cycle):
  - bus_* driven from latched registers. bus_wr_en = we & mapped; bus_rd_en = ~we & mapped.
  - bus_rdata captured at clock edge.
  - Go to RESP.
- RESP (1 cycle):
  - Owner's ack = 1. rdata = captured value on reads; holds the last read value on writes.
  - err = 1 if unmapped and ERR_ON_UNMAPPED; rdata forced 0 on error.
  - Go to IDLE.
- Latency: req sampled at edge N → strobe during cycle N+1 → ack during cycle N+2. Throughput is one transaction per 3 cycles.
- Masters must deassert or replace req in the cycle after ack. A req still high in IDLE is treated as a new transaction.
- Request fields change while waiting (not yet granted): the value sampled at grant is used. No field is sampled afterwards.
- Unmapped with ERR_ON_UNMAPPED=0: strobe issued anyway, rdata is whatever bus_rdata returns (0 from the mux).
- Strobes are never asserted outside ACCESS. They are never both high.
- Request arriving during ACCESS/RESP: waits, and is arbitrated in the next IDLE.
- No starvation: under continuous requests from both masters, grants strictly alternate.
- Reset mid-ACCESS: strobes drop asynchronously, no ack is issued, the transaction is lost.

Decomposition:
- Extend the shared bus definitions header alongside memory_map.vh with FSM state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), master IDs (M0=0, M1=1), and an IS_MAPPED macro built from the existing IS_*_MEM macros.
- One sub-module, rr_pick2: combinational two-way round-robin pick from {req0, req1, last_owner} → {grant_valid, grant_id}. The pointer register stays in the parent.

Test Plan:
- M0 read of 0x1000_0010 alone (mem word 0xDEADBEEF) → bus_rd_en high exactly 1 cycle, bus_addr = 0x1000_0010; m0_ack 2 cycles after req sampled; m0_rdata = 0xDEADBEEF; m0_err = 0.
- M0 and M1 request together from reset (M0_FIRST=1), both held continuously → grants M0, M1, M0, M1, with acks 3 cycles apart; bus_owner toggles.
- M1 write 0x0000_00A5 with byte_en 4'b0001 to a data address → bus_wr_en 1 cycle, bus_byte_en = 4'b0001; then M0 read of the same address returns 0x??????A5 with the low byte = 0xA5.
- M0 read of unmapped 0xF000_0000 → no strobe; m0_ack with m0_err = 1, m0_rdata = 0.
- rst asserted mid-ACCESS → bus_rd_en/bus_wr_en drop the same cycle, no ack, FSM in IDLE; after release, the held request completes normally.
- M1 requests during an M0 ACCESS → M1 is granted in the IDLE right after M0's RESP, with no lost or duplicated ack.
